ex_wb_stage: RTL and testbench
==============================

EX_WB_STAGE -- requirements
Module: ex_wb_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; SHALL match the ALU result width.
REQ-002 Parameter RD_W, default 6, destination-register index width.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge only.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 stall  in  1  hold all state this cycle.
REQ-006 flush  in  1  squash the instruction being captured this cycle.
REQ-007 in_valid  in  1  the EX-stage instruction is real (not a bubble).
REQ-008 alu_out  in  DATA_W  ALU result.
REQ-009 alu_z / alu_n  in  1 each  ALU zero and negative flags.
REQ-010 mem_data  in  DATA_W  data-memory read data.
REQ-011 rd  in  RD_W  destination register index.
REQ-012 reg_write  in  1  the instruction writes the register file.
REQ-013 mem_to_reg  in  1  select mem_data (1) or alu_out (0) for writeback.
REQ-014 flag_we  in  1  the instruction is an ALU op (add/inc/neg/sub) that updates the flags.
REQ-015 brz / brn / jmp  in  1 each  branch-if-Z, branch-if-N, and unconditional jump.
REQ-016 br_target  in  DATA_W  branch/jump target address.
REQ-017 wb_data  out  DATA_W  registered writeback data.
REQ-018 wb_rd  out  RD_W  registered destination index.
REQ-019 wb_we  out  1  registered register-file write enable.
REQ-020 flag_z / flag_n  out  1 each  architectural flag register.
REQ-021 branch_taken  out  1  registered redirect request, a one-cycle pulse per taken branch.
REQ-022 branch_pc  out  DATA_W  registered redirect address.

Function
REQ-023 Priority on each rising edge: rst > flush > stall > normal capture.
REQ-024 Normal capture: wb_data <= mem_to_reg ? mem_data : alu_out; wb_rd <= rd; wb_we <= in_valid & reg_write.
REQ-025 Flags: when in_valid & flag_we, flag_z <= alu_z and flag_n <= alu_n; otherwise the flags hold.
REQ-026 Branch decision SHALL use the flag register values present before this edge, never alu_z/alu_n of the same instruction.
REQ-027 branch_taken <= in_valid & (jmp | (brz & flag_z) | (brn & flag_n)); branch_pc <= br_target when the branch is taken, else branch_pc holds.
REQ-028 flush: wb_we <= 0 and branch_taken <= 0; flags, wb_data, wb_rd and branch_pc hold; flush overrides stall.
REQ-029 stall without flush: every register holds, including branch_taken. The fetch stage consumes a held pulse only once.
REQ-030 flag_we and brz/brn asserted together: flags update and the branch uses the pre-update flags (REQ-026).
REQ-031 in_valid=0: wb_we, branch_taken <= 0; flags do not update; wb_data and wb_rd are still captured (don't-care).
REQ-032 Latency: exactly one cycle from EX inputs to wb_*/branch_* outputs; no combinational path from inputs to outputs.
REQ-033 brz and brn both asserted: taken if either condition holds.

Reset
REQ-034 rst=1 at an edge: wb_data=0, wb_rd=0, wb_we=0, flag_z=0, flag_n=0, branch_taken=0, branch_pc=0, regardless of stall/flush.
REQ-035 rst asserted mid-stall or mid-branch: reset values SHALL appear after that edge and any pending redirect is dropped.

Verification
REQ-036 ALU add: alu_out=0x0000_0005, rd=3, reg_write=1, flag_we=1, alu_z=0, alu_n=0 -> next cycle wb_data=5, wb_rd=3, wb_we=1, flags 0/0.
REQ-037 sub with alu_out=0, alu_z=1, then brz with br_target=0x40 -> branch_taken=1 for one cycle, branch_pc=0x40.
REQ-038 flags Z=0; an instruction with flag_we=1, alu_z=1 and brz=1 -> branch_taken=0, flag_z=1 after the edge.
REQ-039 load: mem_to_reg=1, mem_data=0xDEAD_BEEF, alu_out=0x10 -> wb_data=0xDEAD_BEEF.
REQ-040 stall=1 for 3 cycles with changing inputs -> all outputs constant; stall=1 and flush=1 together -> wb_we=0, branch_taken=0.
REQ-041 rst=1 while wb_we=1, flag_n=1, branch_taken=1 -> all outputs 0 after the edge.

Source files
------------

// File: rtl/ex_wb_stage.sv
// ex_wb_stage
//
// EX/WB pipeline register with the architectural Z/N flag register and
// the branch-redirect register. Every output is registered, so there is
// exactly one cycle from the EX-stage inputs to the outputs and no
// combinational path from an input to an output.
//
// Ports
//   clk           clock; all state updates on the rising edge
//   rst           synchronous, active-high reset
//   stall         hold every register this cycle
//   flush         squash the instruction being captured (overrides stall)
//   in_valid      EX instruction is real (not a bubble)
//   alu_out       ALU result
//   alu_z, alu_n  ALU zero / negative flags of this instruction
//   mem_data      data-memory read data
//   rd            destination register index
//   reg_write     instruction writes the register file
//   mem_to_reg    writeback source: 1 = mem_data, 0 = alu_out
//   flag_we       instruction is a flag-updating ALU op
//   brz, brn, jmp branch-if-Z, branch-if-N, unconditional jump
//   br_target     branch/jump target address
//   wb_data       registered writeback data
//   wb_rd         registered destination index
//   wb_we         registered register-file write enable
//   flag_z/flag_n architectural flag register
//   branch_taken  one-cycle redirect pulse per taken branch
//   branch_pc     registered redirect address

module ex_wb_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [RD_W-1:0]   rd,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic              flag_we,
    input  logic              brz,
    input  logic              brn,
    input  logic              jmp,
    input  logic [DATA_W-1:0] br_target,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              wb_we,
    output logic              flag_z,
    output logic              flag_n,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_pc
);

    logic take;

    // The condition reads the flag register, i.e. the values from before
    // this edge, so an ALU op that also branches sees the previous flags.
    always_comb begin
        take = in_valid & (jmp | (brz & flag_z) | (brn & flag_n));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_we        <= 1'b0;
            flag_z       <= 1'b0;
            flag_n       <= 1'b0;
            branch_taken <= 1'b0;
            branch_pc    <= '0;
        end else if (flush) begin
            // Kill the side effects only; data, index, flags and pc hold.
            wb_we        <= 1'b0;
            branch_taken <= 1'b0;
        end else if (!stall) begin
            wb_data      <= mem_to_reg ? mem_data : alu_out;
            wb_rd        <= rd;
            wb_we        <= in_valid & reg_write;
            if (in_valid && flag_we) begin
                flag_z <= alu_z;
                flag_n <= alu_n;
            end
            branch_taken <= take;
            if (take) begin
                branch_pc <= br_target;
            end
        end
    end

endmodule

// File: tb/tb_ex_wb_stage.sv
module tb_ex_wb_stage;

    localparam int DW = 32;
    localparam int RW = 6;

    typedef struct packed {
        logic [DW-1:0] wb_data;
        logic [RW-1:0] wb_rd;
        logic          wb_we;
        logic          fz;
        logic          fn;
        logic          bt;
        logic [DW-1:0] bpc;
    } out_t;

    typedef struct packed {
        logic          rst;
        logic          stall;
        logic          flush;
        logic          in_valid;
        logic [DW-1:0] alu_out;
        logic          z;
        logic          n;
        logic [DW-1:0] mem_data;
        logic [RW-1:0] rd;
        logic          reg_write;
        logic          mem_to_reg;
        logic          flag_we;
        logic          brz;
        logic          brn;
        logic          jmp;
        logic [DW-1:0] br_target;
    } in_t;

    logic          clk = 1'b0;
    logic          rst, stall, flush, in_valid, alu_z, alu_n;
    logic [DW-1:0] alu_out, mem_data, br_target;
    logic [RW-1:0] rd;
    logic          reg_write, mem_to_reg, flag_we, brz, brn, jmp;
    logic [DW-1:0] wb_data, branch_pc;
    logic [RW-1:0] wb_rd;
    logic          wb_we, flag_z, flag_n, branch_taken;

    int   n_checks = 0;
    int   n_fail   = 0;
    out_t exp_q[$];
    out_t model_s  = '0;

    always #5 clk = ~clk;

    ex_wb_stage #(.DATA_W(DW), .RD_W(RW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .mem_data(mem_data),
        .rd(rd), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .flag_we(flag_we),
        .brz(brz), .brn(brn), .jmp(jmp), .br_target(br_target),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we), .flag_z(flag_z),
        .flag_n(flag_n), .branch_taken(branch_taken), .branch_pc(branch_pc)
    );

    // Reference: next architectural state from the rule list
    // rst > flush > stall > capture; branch uses the flags held in s.
    function automatic out_t model(out_t s, in_t i);
        out_t r;
        logic t;
        r = s;
        if (i.rst) begin
            r = '0;
        end else if (i.flush) begin
            r.wb_we = 1'b0;
            r.bt    = 1'b0;
        end else if (!i.stall) begin
            r.wb_data = i.mem_to_reg ? i.mem_data : i.alu_out;
            r.wb_rd   = i.rd;
            r.wb_we   = i.in_valid && i.reg_write;
            if (i.in_valid && i.flag_we) begin
                r.fz = i.z;
                r.fn = i.n;
            end
            t = i.in_valid && (i.jmp || (i.brz && s.fz) || (i.brn && s.fn));
            r.bt = t;
            if (t) r.bpc = i.br_target;
        end
        return r;
    endfunction

    task automatic apply(input in_t i);
        rst = i.rst; stall = i.stall; flush = i.flush; in_valid = i.in_valid;
        alu_out = i.alu_out; alu_z = i.z; alu_n = i.n; mem_data = i.mem_data;
        rd = i.rd; reg_write = i.reg_write; mem_to_reg = i.mem_to_reg;
        flag_we = i.flag_we; brz = i.brz; brn = i.brn; jmp = i.jmp;
        br_target = i.br_target;
        model_s = model(model_s, i);
        exp_q.push_back(model_s);
        @(negedge clk);
    endtask

    function automatic in_t rnd_in();
        in_t i;
        i.rst        = 1'b0;
        i.stall      = ($urandom_range(0, 5) == 0);
        i.flush      = ($urandom_range(0, 7) == 0);
        i.in_valid   = ($urandom_range(0, 4) != 0);
        i.alu_out    = $urandom;
        i.z          = $urandom_range(0, 1);
        i.n          = $urandom_range(0, 1);
        i.mem_data   = $urandom;
        i.rd         = RW'($urandom);
        i.reg_write  = $urandom_range(0, 1);
        i.mem_to_reg = $urandom_range(0, 1);
        i.flag_we    = $urandom_range(0, 1);
        i.brz        = $urandom_range(0, 1);
        i.brn        = $urandom_range(0, 1);
        i.jmp        = ($urandom_range(0, 3) == 0);
        i.br_target  = $urandom;
        return i;
    endfunction

    // Monitor: every rising edge produces one registered response.
    initial begin
        out_t act, e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = '{wb_data, wb_rd, wb_we, flag_z, flag_n, branch_taken, branch_pc};
                n_checks++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got data=%h rd=%0d we=%b z=%b n=%b bt=%b pc=%h, want data=%h rd=%0d we=%b z=%b n=%b bt=%b pc=%h",
                             $time, act.wb_data, act.wb_rd, act.wb_we, act.fz, act.fn, act.bt, act.bpc,
                             e.wb_data, e.wb_rd, e.wb_we, e.fz, e.fn, e.bt, e.bpc);
                end
            end
        end
    end

    initial begin
        in_t i;
        // Reset
        i = '0; i.rst = 1'b1;
        apply(i); apply(i);
        // Add: 5 -> r3, flags 0/0
        i = '0; i.in_valid = 1; i.alu_out = 32'h5; i.rd = 3; i.reg_write = 1; i.flag_we = 1;
        apply(i);
        // Sub producing zero, then brz to 0x40, then a bubble (pulse ends, pc holds)
        i = '0; i.in_valid = 1; i.alu_out = 0; i.z = 1; i.flag_we = 1; i.reg_write = 1; i.rd = 7;
        apply(i);
        i = '0; i.in_valid = 1; i.brz = 1; i.br_target = 32'h40;
        apply(i);
        i = '0;
        apply(i);
        // Z cleared, then flag-updating op with brz: not taken, Z set after
        i = '0; i.in_valid = 1; i.flag_we = 1;
        apply(i);
        i = '0; i.in_valid = 1; i.flag_we = 1; i.z = 1; i.brz = 1; i.br_target = 32'h80;
        apply(i);
        // Now Z=1: brz and brn together, taken
        i = '0; i.in_valid = 1; i.brz = 1; i.brn = 1; i.br_target = 32'h44;
        apply(i);
        // Load selects mem_data
        i = '0; i.in_valid = 1; i.mem_to_reg = 1; i.mem_data = 32'hDEAD_BEEF;
        i.alu_out = 32'h10; i.reg_write = 1; i.rd = 9;
        apply(i);
        // Invalid instruction: no write, no branch, no flag change
        i = '0; i.alu_out = 32'h1234; i.rd = 5; i.reg_write = 1; i.flag_we = 1; i.n = 1; i.jmp = 1;
        apply(i);
        // Jump with writeback, then stall three cycles with changing inputs
        i = '0; i.in_valid = 1; i.jmp = 1; i.br_target = 32'hCAFE; i.reg_write = 1;
        i.alu_out = 32'h77; i.rd = 2;
        apply(i);
        for (int k = 0; k < 3; k++) begin
            i = rnd_in(); i.stall = 1; i.flush = 0;
            apply(i);
        end
        // Stall and flush together
        i = rnd_in(); i.stall = 1; i.flush = 1;
        apply(i);
        // Build wb_we=1, flag_n=1, branch_taken=1, then reset
        i = '0; i.in_valid = 1; i.reg_write = 1; i.flag_we = 1; i.n = 1; i.jmp = 1;
        i.br_target = 32'h100; i.alu_out = 32'hFF; i.rd = 1;
        apply(i);
        i = rnd_in(); i.rst = 1; i.stall = 1;
        apply(i);
        // Randomized traffic with occasional reset
        for (int k = 0; k < 400; k++) begin
            i = rnd_in();
            i.rst = ($urandom_range(0, 49) == 0);
            apply(i);
        end
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses never observed, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
